pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
- Controller for a single altpll instance. It pulses the PLL reset, waits for lock and qualifies lock over a stable window.
- On qualified lock, releases a synchronous downstream reset. On loss of lock it re-sequences, with bounded retries.
- Runs on the PLL reference clock inclk0, never on a PLL output. Sits between board reset and all logic clocked by c0..c5.

Parameters:
- RST_CYCLES, 8, cycles pll_areset is held high per attempt (≥1).
- LOCK_WINDOW, 16, consecutive synced-locked cycles needed to qualify lock (≥1).
- LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK/QUALIFY before an attempt fails.
- MAX_RETRY, 3, failed attempts tolerated before FAIL (attempts = MAX_RETRY+1).
- CNT_W, 16, internal counter width; must hold max(RST_CYCLES, LOCK_WINDOW, LOCK_TIMEOUT).

Ports:
- inclk0  in  1  reference clock; all logic on rising edge.
- areset_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; restarts sequencing from RESET (any state).
- pll_locked  in  1  raw PLL locked; asynchronous, synchronised internally by 2 flops.
- pll_areset  out  1  to PLL areset, active high.
- clk_ready  out  1  high only in LOCKED.
- sys_rst_n  out  1  downstream reset, low except in LOCKED.
- fail  out  1  high only in FAIL.
- retry_cnt  out  2  failed attempts in current sequence, saturating at 3.
- loss_cnt  out  8  lock-loss events since reset, saturating at 255.

Behaviour:
- Reset (areset_n=0, async):
  - state=RESET, counter=0, sync flops=0, retry_cnt=0, loss_cnt=0.
  - pll_areset=1, clk_ready=0, sys_rst_n=0, fail=0.
- Sync: lk = pll_locked after 2 inclk0 flops (2-cycle latency). All decisions use lk only.
- States and transitions:
  - RESET: pll_areset=1. Counter counts 0..RST_CYCLES-1, then goes to WAIT_LOCK with counter cleared. Exactly RST_CYCLES cycles high.
  - WAIT_LOCK: pll_areset=0, counter = timeout counter.
    - lk=1 → QUALIFY; window count=1, timeout keeps running.
    - Timeout reaches LOCK_TIMEOUT-1 → attempt fails.
  - QUALIFY:
    - lk=1 increments window. Window reaching LOCK_WINDOW → LOCKED; clear retry_cnt.
    - lk=0 → back to WAIT_LOCK; window cleared, timeout not cleared.
    - Timeout expiry → attempt fails.
  - Attempt fail: if retry_cnt==MAX_RETRY → FAIL; else retry_cnt+1 and → RESET.
  - LOCKED: clk_ready=1, sys_rst_n=1 (registered; both rise the cycle after entry).
    - lk=0 → loss_cnt+1 (saturate), retry_cnt=0, → RESET.
  - FAIL: pll_areset=1 held. Exits only via start or areset_n.
- start=1 in any state → RESET, counter=0, retry_cnt=0. start beats lk and timeout in the same cycle.
- Simultaneous QUALIFY window completion and timeout expiry: lock wins.
- Outputs are registered, no combinational paths input→output.
- Minimum qualified-lock latency after areset_n deassert: RST_CYCLES + 2 (sync) + LOCK_WINDOW + 1 cycles.

Optional Feature:
- Macro: PLL_LOSS_FILTER_EN.
- Defined: in LOCKED, lk must stay 0 for LOSS_FILTER (parameter, default 4) consecutive cycles before loss is declared. Shorter glitches are ignored and not counted, and outputs stay asserted. For radiation/SEU environments.
- Undefined: a single cycle of lk=0 in LOCKED declares loss. The LOSS_FILTER parameter still exists but is unused.

Test Plan:
- Nominal: deassert areset_n; pll_locked=1 from cycle 20.
  - pll_areset high exactly 8 cycles.
  - clk_ready and sys_rst_n rise 2+16+1 cycles after lk source rises; retry_cnt=0.
- Never lock: pll_locked=0 throughout.
  - 4 RESET pulses of 8 cycles, each WAIT_LOCK 4096 cycles.
  - Then fail=1, pll_areset=1, retry_cnt=3.
  - start pulse → RESET, retry_cnt=0.
- Chatter: pll_locked toggles 10 cycles high / 2 low.
  - QUALIFY never completes; timeout → retry_cnt=1.
  - Then steady lock → LOCKED, retry_cnt=0.
- Loss of lock: from LOCKED drop pll_locked for 1 cycle.
  - Filter off: loss_cnt=1, sys_rst_n low within 3 cycles, re-sequence.
  - PLL_LOSS_FILTER_EN: no state change for glitches of 1–3 cycles; a 4-cycle drop → loss_cnt=1.
- Reset/start mid-operation:
  - areset_n low during QUALIFY → outputs at reset values immediately (async).
  - start at the same cycle as window completion → RESET, not LOCKED.
- Saturation: force 260 loss events → loss_cnt stays 255.

Source files
------------

// File: rtl/pll_lock_sequencer_if.sv
// Handshake bundle between the PLL lock sequencer and its environment
// (PLL control/status plus downstream clock-ready and reset outputs).
interface pll_lock_sequencer_if;
   logic       start;
   logic       pll_locked;
   logic       pll_areset;
   logic       clk_ready;
   logic       sys_rst_n;
   logic       fail;
   logic [1:0] retry_cnt;
   logic [7:0] loss_cnt;

   // Environment side: issues start, reports raw lock, observes sequencer state
   modport master (
      output start,
      output pll_locked,
      input  pll_areset,
      input  clk_ready,
      input  sys_rst_n,
      input  fail,
      input  retry_cnt,
      input  loss_cnt
   );

   // Sequencer side
   modport slave (
      input  start,
      input  pll_locked,
      output pll_areset,
      output clk_ready,
      output sys_rst_n,
      output fail,
      output retry_cnt,
      output loss_cnt
   );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses the PLL reset, waits for lock, qualifies it over a
// stable window, then releases the downstream reset. Re-sequences on loss of lock
// with bounded retries. Runs on the PLL reference clock.
// Optional macro PLL_LOSS_FILTER_EN: require LOSS_FILTER consecutive unlocked
// cycles in LOCKED before declaring loss.
module pll_lock_sequencer #(
   parameter int unsigned RST_CYCLES   = 8,
   parameter int unsigned LOCK_WINDOW  = 16,
   parameter int unsigned LOCK_TIMEOUT = 4096,
   parameter int unsigned MAX_RETRY    = 3,
   parameter int unsigned LOSS_FILTER  = 4,
   parameter int unsigned CNT_W        = 16
) (
   input logic                 inclk0,
   input logic                 areset_n,
   pll_lock_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      StReset,
      StWaitLock,
      StQualify,
      StLocked,
      StFail
   } state_e;

   localparam logic [CNT_W-1:0] RstLast     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] WindowLast  = CNT_W'(LOCK_WINDOW - 1);
   localparam logic [1:0]       MaxRetry    = 2'(MAX_RETRY);

   if (RST_CYCLES < 1 || LOCK_WINDOW < 1 || LOCK_TIMEOUT < 1 || LOSS_FILTER < 1 ||
       MAX_RETRY > 3) begin : g_bad_param
      $error("pll_lock_sequencer: illegal parameter value");
   end

   state_e           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_win;
   logic [1:0]       r_retry;
   logic [7:0]       r_loss;
   logic             r_pll_areset;
   logic             r_clk_ready;
   logic             r_sys_rst_n;
   logic             r_fail;
   logic             r_sync1;
   logic             r_sync2;

   logic w_lk;
   logic w_timeout;
   logic w_win_done;
   logic w_attempt_fail;
   logic w_loss;

   assign w_lk       = r_sync2;
   assign w_timeout  = (r_cnt == TimeoutLast);
   assign w_win_done = w_lk && (r_win == WindowLast);
   // In QUALIFY a completing window beats a simultaneous timeout
   assign w_attempt_fail = ((r_state == StWaitLock) && w_timeout) ||
                           ((r_state == StQualify) && w_timeout && !w_win_done);

`ifdef PLL_LOSS_FILTER_EN
   localparam logic [CNT_W-1:0] LfLast = CNT_W'(LOSS_FILTER - 1);
   logic [CNT_W-1:0] r_lf;

   assign w_loss = !w_lk && (r_lf == LfLast);

   // Count consecutive unlocked cycles while LOCKED; any locked cycle clears it
   always_ff @(posedge inclk0 or negedge areset_n) begin
      if (!areset_n) begin
         r_lf <= '0;
      end else if ((r_state == StLocked) && !w_lk && !bus.start) begin
         r_lf <= r_lf + CNT_W'(1);
      end else begin
         r_lf <= '0;
      end
   end
`else
   assign w_loss = !w_lk;
`endif

   // Two-flop synchroniser for the asynchronous PLL lock indication
   always_ff @(posedge inclk0 or negedge areset_n) begin
      if (!areset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= bus.pll_locked;
         r_sync2 <= r_sync1;
      end
   end

   // Sequencing FSM with registered outputs
   always_ff @(posedge inclk0 or negedge areset_n) begin
      if (!areset_n) begin
         r_state      <= StReset;
         r_cnt        <= '0;
         r_win        <= '0;
         r_retry      <= '0;
         r_loss       <= '0;
         r_pll_areset <= 1'b1;
         r_clk_ready  <= 1'b0;
         r_sys_rst_n  <= 1'b0;
         r_fail       <= 1'b0;
      end else if (bus.start) begin
         r_state      <= StReset;
         r_cnt        <= '0;
         r_win        <= '0;
         r_retry      <= '0;
         r_pll_areset <= 1'b1;
         r_clk_ready  <= 1'b0;
         r_sys_rst_n  <= 1'b0;
         r_fail       <= 1'b0;
      end else if (w_attempt_fail) begin
         r_win        <= '0;
         r_pll_areset <= 1'b1;
         if (r_retry == MaxRetry) begin
            r_state <= StFail;
            r_fail  <= 1'b1;
         end else begin
            r_state <= StReset;
            r_cnt   <= '0;
            r_retry <= r_retry + 2'd1;
         end
      end else begin
         unique case (r_state)
            StReset: begin
               if (r_cnt == RstLast) begin
                  r_state      <= StWaitLock;
                  r_cnt        <= '0;
                  r_pll_areset <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            StWaitLock: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_lk) begin
                  r_win <= CNT_W'(1);
                  if (LOCK_WINDOW == 1) begin
                     r_state <= StLocked;
                     r_retry <= '0;
                  end else begin
                     r_state <= StQualify;
                  end
               end
            end
            StQualify: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_win_done) begin
                  r_state <= StLocked;
                  r_retry <= '0;
               end else if (w_lk) begin
                  r_win <= r_win + CNT_W'(1);
               end else begin
                  r_state <= StWaitLock;
                  r_win   <= '0;
               end
            end
            StLocked: begin
               if (w_loss) begin
                  r_state      <= StReset;
                  r_cnt        <= '0;
                  r_win        <= '0;
                  r_retry      <= '0;
                  r_loss       <= (r_loss == 8'hFF) ? r_loss : r_loss + 8'd1;
                  r_pll_areset <= 1'b1;
                  r_clk_ready  <= 1'b0;
                  r_sys_rst_n  <= 1'b0;
               end else begin
                  // Outputs rise one cycle after entering LOCKED
                  r_clk_ready <= 1'b1;
                  r_sys_rst_n <= 1'b1;
               end
            end
            StFail: begin
               r_pll_areset <= 1'b1;
            end
            default: begin
               r_state      <= StReset;
               r_cnt        <= '0;
               r_pll_areset <= 1'b1;
            end
         endcase
      end
   end

   assign bus.pll_areset = r_pll_areset;
   assign bus.clk_ready  = r_clk_ready;
   assign bus.sys_rst_n  = r_sys_rst_n;
   assign bus.fail       = r_fail;
   assign bus.retry_cnt  = r_retry;
   assign bus.loss_cnt   = r_loss;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with default parameters.
// Output vector layout: {pll_areset, clk_ready, sys_rst_n, fail, retry_cnt, loss_cnt}.
module tb_pll_lock_sequencer;

`ifdef PLL_LOSS_FILTER_EN
   localparam int Drop = 4;
`else
   localparam int Drop = 1;
`endif

   logic inclk0;
   logic areset_n;
   int   total;
   int   bad;

   pll_lock_sequencer_if bus ();

   pll_lock_sequencer dut (
      .inclk0   (inclk0),
      .areset_n (areset_n),
      .bus      (bus)
   );

   initial begin
      inclk0 = 1'b0;
      forever #5 inclk0 = ~inclk0;
   end

   function automatic logic [13:0] outs();
      return {bus.pll_areset, bus.clk_ready, bus.sys_rst_n, bus.fail, bus.retry_cnt,
              bus.loss_cnt};
   endfunction

   function automatic logic [13:0] vec(input int pa, input int cr, input int sr, input int f,
                                       input int rc, input int lc);
      return {pa[0], cr[0], sr[0], f[0], rc[1:0], lc[7:0]};
   endfunction

   // Advance n rising edges, then settle 1 time unit past the edge
   task automatic step(input int n);
      repeat (n) @(posedge inclk0);
      #1;
   endtask

   // Hold reset for two edges; on return the next rising edge is edge 1
   task automatic do_reset(input logic lock);
      areset_n       = 1'b0;
      bus.start      = 1'b0;
      bus.pll_locked = lock;
      step(2);
      areset_n = 1'b1;
   endtask

   task automatic test_reset();
      areset_n       = 1'b0;
      bus.start      = 1'b0;
      bus.pll_locked = 1'b1;
      step(3);
      total++;
      if (outs() !== vec(1, 0, 0, 0, 0, 0)) begin
         bad++;
         $display("FAIL reset_hold: got %b want %b", outs(), vec(1, 0, 0, 0, 0, 0));
      end
   endtask

   task automatic test_nominal();
      do_reset(1'b0);
      step(7);
      total++;
      if (outs() !== vec(1, 0, 0, 0, 0, 0)) begin
         bad++;
         $display("FAIL nom_areset_e7: got %b want %b", outs(), vec(1, 0, 0, 0, 0, 0));
      end
      step(1);
      total++;
      if (outs() !== vec(0, 0, 0, 0, 0, 0)) begin
         bad++;
         $display("FAIL nom_areset_e8: got %b want %b", outs(), vec(0, 0, 0, 0, 0, 0));
      end
      step(12);
      bus.pll_locked = 1'b1;
      step(18);
      total++;
      if (outs() !== vec(0, 0, 0, 0, 0, 0)) begin
         bad++;
         $display("FAIL nom_ready_early: got %b want %b", outs(), vec(0, 0, 0, 0, 0, 0));
      end
      step(1);
      total++;
      if (outs() !== vec(0, 1, 1, 0, 0, 0)) begin
         bad++;
         $display("FAIL nom_ready: got %b want %b", outs(), vec(0, 1, 1, 0, 0, 0));
      end
   endtask

   // Continues from LOCKED with loss_cnt = 0
   task automatic test_loss();
`ifdef PLL_LOSS_FILTER_EN
      bus.pll_locked = 1'b0;
      step(3);
      bus.pll_locked = 1'b1;
      step(8);
      total++;
      if (outs() !== vec(0, 1, 1, 0, 0, 0)) begin
         bad++;
         $display("FAIL loss_glitch_ignored: got %b want %b", outs(), vec(0, 1, 1, 0, 0, 0));
      end
`endif
      bus.pll_locked = 1'b0;
      step(Drop);
      bus.pll_locked = 1'b1;
      step(1);
      total++;
      if (outs() !== vec(0, 1, 1, 0, 0, 0)) begin
         bad++;
         $display("FAIL loss_before: got %b want %b", outs(), vec(0, 1, 1, 0, 0, 0));
      end
      step(1);
      total++;
      if (outs() !== vec(1, 0, 0, 0, 0, 1)) begin
         bad++;
         $display("FAIL loss_declared: got %b want %b", outs(), vec(1, 0, 0, 0, 0, 1));
      end
   endtask

   // Continues right after a loss event; re-qualification is in progress
   task automatic test_async_reset_mid_qualify();
      step(10);
      total++;
      if (outs() !== vec(0, 0, 0, 0, 0, 1)) begin
         bad++;
         $display("FAIL qual_before: got %b want %b", outs(), vec(0, 0, 0, 0, 0, 1));
      end
      #2 areset_n = 1'b0;
      #1;
      total++;
      if (outs() !== vec(1, 0, 0, 0, 0, 0)) begin
         bad++;
         $display("FAIL async_reset: got %b want %b", outs(), vec(1, 0, 0, 0, 0, 0));
      end
   endtask

   task automatic test_start_at_lock();
      do_reset(1'b1);
      step(23);
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      total++;
      if (outs() !== vec(1, 0, 0, 0, 0, 0)) begin
         bad++;
         $display("FAIL start_beats_lock: got %b want %b", outs(), vec(1, 0, 0, 0, 0, 0));
      end
      step(1);
      total++;
      if (outs() !== vec(1, 0, 0, 0, 0, 0)) begin
         bad++;
         $display("FAIL start_not_locked: got %b want %b", outs(), vec(1, 0, 0, 0, 0, 0));
      end
      step(7);
      total++;
      if (outs() !== vec(0, 0, 0, 0, 0, 0)) begin
         bad++;
         $display("FAIL start_rst_len: got %b want %b", outs(), vec(0, 0, 0, 0, 0, 0));
      end
      step(17);
      total++;
      if (outs() !== vec(0, 1, 1, 0, 0, 0)) begin
         bad++;
         $display("FAIL start_relock: got %b want %b", outs(), vec(0, 1, 1, 0, 0, 0));
      end
   endtask

   task automatic test_never_lock();
      do_reset(1'b0);
      step(8);
      total++;
      if (outs() !== vec(0, 0, 0, 0, 0, 0)) begin
         bad++;
         $display("FAIL nl_wait1: got %b want %b", outs(), vec(0, 0, 0, 0, 0, 0));
      end
      step(4095);
      total++;
      if (outs() !== vec(0, 0, 0, 0, 0, 0)) begin
         bad++;
         $display("FAIL nl_before_timeout: got %b want %b", outs(), vec(0, 0, 0, 0, 0, 0));
      end
      step(1);
      total++;
      if (outs() !== vec(1, 0, 0, 0, 1, 0)) begin
         bad++;
         $display("FAIL nl_retry1: got %b want %b", outs(), vec(1, 0, 0, 0, 1, 0));
      end
      step(12311);
      total++;
      if (outs() !== vec(0, 0, 0, 0, 3, 0)) begin
         bad++;
         $display("FAIL nl_last_wait: got %b want %b", outs(), vec(0, 0, 0, 0, 3, 0));
      end
      step(1);
      total++;
      if (outs() !== vec(1, 0, 0, 1, 3, 0)) begin
         bad++;
         $display("FAIL nl_fail: got %b want %b", outs(), vec(1, 0, 0, 1, 3, 0));
      end
      step(50);
      total++;
      if (outs() !== vec(1, 0, 0, 1, 3, 0)) begin
         bad++;
         $display("FAIL nl_fail_hold: got %b want %b", outs(), vec(1, 0, 0, 1, 3, 0));
      end
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      total++;
      if (outs() !== vec(1, 0, 0, 0, 0, 0)) begin
         bad++;
         $display("FAIL nl_start: got %b want %b", outs(), vec(1, 0, 0, 0, 0, 0));
      end
   endtask

   task automatic test_chatter();
      logic saw_ready;
      saw_ready = 1'b0;
      do_reset(1'b0);
      for (int k = 0; k < 4103; k++) begin
         bus.pll_locked = (k % 12) < 10;
         step(1);
         if (bus.clk_ready) saw_ready = 1'b1;
      end
      total++;
      if (saw_ready !== 1'b0) begin
         bad++;
         $display("FAIL chat_no_lock: got %b want 0", saw_ready);
      end
      total++;
      if (outs() !== vec(0, 0, 0, 0, 0, 0)) begin
         bad++;
         $display("FAIL chat_before_timeout: got %b want %b", outs(), vec(0, 0, 0, 0, 0, 0));
      end
      bus.pll_locked = 1'b0;
      step(1);
      total++;
      if (outs() !== vec(1, 0, 0, 0, 1, 0)) begin
         bad++;
         $display("FAIL chat_retry1: got %b want %b", outs(), vec(1, 0, 0, 0, 1, 0));
      end
      bus.pll_locked = 1'b1;
      step(23);
      total++;
      if (outs() !== vec(0, 0, 0, 0, 1, 0)) begin
         bad++;
         $display("FAIL chat_qualify: got %b want %b", outs(), vec(0, 0, 0, 0, 1, 0));
      end
      step(1);
      total++;
      if (outs() !== vec(0, 0, 0, 0, 0, 0)) begin
         bad++;
         $display("FAIL chat_retry_clr: got %b want %b", outs(), vec(0, 0, 0, 0, 0, 0));
      end
      step(1);
      total++;
      if (outs() !== vec(0, 1, 1, 0, 0, 0)) begin
         bad++;
         $display("FAIL chat_locked: got %b want %b", outs(), vec(0, 1, 1, 0, 0, 0));
      end
   endtask

   task automatic test_saturation();
      int n;
      do_reset(1'b1);
      for (int ev = 1; ev <= 260; ev++) begin
         n = 0;
         while (!bus.clk_ready && n < 100) begin
            step(1);
            n++;
         end
         if (n == 100) begin
            total++;
            bad++;
            $display("FAIL sat_wait_ready: event %0d got clk_ready=0 want 1 within 100", ev);
            break;
         end
         bus.pll_locked = 1'b0;
         step(Drop);
         bus.pll_locked = 1'b1;
         step(2);
         if (ev == 200) begin
            total++;
            if (bus.loss_cnt !== 8'd200) begin
               bad++;
               $display("FAIL sat_count200: got %0d want 200", bus.loss_cnt);
            end
         end
         if (ev == 255) begin
            total++;
            if (bus.loss_cnt !== 8'd255) begin
               bad++;
               $display("FAIL sat_count255: got %0d want 255", bus.loss_cnt);
            end
         end
      end
      total++;
      if (bus.loss_cnt !== 8'd255) begin
         bad++;
         $display("FAIL sat_hold: got %0d want 255", bus.loss_cnt);
      end
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      areset_n       = 1'b0;
      bus.start      = 1'b0;
      bus.pll_locked = 1'b0;
      test_reset();
      test_nominal();
      test_loss();
      test_async_reset_mid_qualify();
      test_start_at_lock();
      test_never_lock();
      test_chatter();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
